// File: rtl/seq_encoder8x3_pkg.sv
// Shared widths, FSM state type and bit-count helper for the sequential 8:3 encoder.
package enc_pkg;

  localparam int VEC_W  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_t;

  // True when at most one bit of v is set (clearing the lowest set bit leaves zero).
  function automatic logic popcnt_le1(input logic [VEC_W-1:0] v);
    return (v & (v - VEC_W'(1))) == '0;
  endfunction

endpackage

// File: rtl/seq_encoder8x3_if.sv
// Request-vector input channel and code output channel of the sequential encoder.
interface seq_encoder8x3_if;
  import enc_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [VEC_W-1:0]  in_vec;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_code;
  logic              out_last;
  logic              out_none;

  // Producer of vectors / consumer of codes.
  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_code, out_last, out_none
  );

  // The encoder itself.
  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_code, out_last, out_none
  );
endinterface

// File: rtl/seq_encoder8x3_pri_enc8.sv
// Combinational 8-bit priority encoder; msb_first selects which end wins.
module pri_enc8
  import enc_pkg::*;
(
  input  logic [VEC_W-1:0]  vec,
  input  logic              msb_first,
  output logic [CODE_W-1:0] code,
  output logic              any,
  output logic              single
);

  logic [CODE_W-1:0] lo_code;
  logic [CODE_W-1:0] hi_code;

  // Scan upward for the highest set bit and downward for the lowest; last hit wins.
  always_comb begin
    lo_code = '0;
    hi_code = '0;
    for (int i = 0; i < VEC_W; i++) begin
      if (vec[i]) hi_code = CODE_W'(i);
    end
    for (int i = VEC_W - 1; i >= 0; i--) begin
      if (vec[i]) lo_code = CODE_W'(i);
    end
  end

  assign code   = msb_first ? hi_code : lo_code;
  assign any    = |vec;
  assign single = any && popcnt_le1(vec);

endmodule

// File: rtl/seq_encoder8x3.sv
// Sequential 8:3 encoder: captures a multi-hot vector and emits one index per beat.
module seq_encoder8x3
  import enc_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_encoder8x3_if.slave   bus
);

  enc_state_t        state_q, state_d;
  logic [VEC_W-1:0]  pend_q, pend_d;
  logic              zero_f_q, zero_f_d;

  logic [CODE_W-1:0] pe_code;
  logic              pe_any;
  logic              pe_single;
  logic              emit;
  logic              last_beat;
  logic [VEC_W-1:0]  emit_mask;

  pri_enc8 u_pri_enc8 (
    .vec       (pend_q),
    .msb_first (MSB_FIRST),
    .code      (pe_code),
    .any       (pe_any),
    .single    (pe_single)
  );

  assign emit      = (state_q == EMIT);
  // At most one bit left (an all-zero capture also lands here) means this beat ends the vector.
  assign last_beat = pe_single || !pe_any;
  assign emit_mask = VEC_W'(1) << pe_code;

  // Outputs depend on registers only; idle outputs are forced to zero.
  assign bus.in_ready  = !emit;
  assign bus.out_valid = emit;
  assign bus.out_code  = (emit && pe_any) ? pe_code : '0;
  assign bus.out_last  = emit && last_beat;
  assign bus.out_none  = emit && zero_f_q;

  // Next-state: capture in IDLE, retire one set bit per accepted beat in EMIT.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    zero_f_d = zero_f_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          pend_d   = bus.in_vec;
          zero_f_d = (bus.in_vec == '0);
          state_d  = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (last_beat) begin
            pend_d   = '0;
            zero_f_d = 1'b0;
            state_d  = IDLE;
          end else begin
            pend_d = pend_q & ~emit_mask;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset discards any beats still pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      zero_f_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      zero_f_q <= zero_f_d;
    end
  end

endmodule

// File: tb/tb_seq_encoder8x3.sv
// Directed scoreboard bench: two encoders (LSB-first and MSB-first) driven in lockstep.
module tb_seq_encoder8x3;
  import enc_pkg::*;

  typedef struct packed {
    logic [2:0] code;
    logic       last;
    logic       none;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  beat_t q0[$];
  beat_t q1[$];

  seq_encoder8x3_if bus0 ();
  seq_encoder8x3_if bus1 ();

  seq_encoder8x3 #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  seq_encoder8x3 #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] v, input logic ordy);
    bus0.in_valid = iv;  bus0.in_vec = v;  bus0.out_ready = ordy;
    bus1.in_valid = iv;  bus1.in_vec = v;  bus1.out_ready = ordy;
  endtask

  // Expected beats of vector v in both orders.
  task automatic push_vec(input logic [7:0] v);
    beat_t b;
    int n;
    int k;
    if (v == 8'h00) begin
      b.code = 3'd0; b.last = 1'b1; b.none = 1'b1;
      q0.push_back(b);
      q1.push_back(b);
    end else begin
      n = $countones(v);
      k = 0;
      for (int i = 0; i < 8; i++) begin
        if (v[i]) begin
          k++;
          b.code = 3'(i); b.last = (k == n); b.none = 1'b0;
          q0.push_back(b);
        end
      end
      k = 0;
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) begin
          k++;
          b.code = 3'(i); b.last = (k == n); b.none = 1'b0;
          q1.push_back(b);
        end
      end
    end
  endtask

  // One cycle: drive inputs at the falling edge, check outputs against the scoreboard.
  task automatic tick(input logic iv, input logic [7:0] v, input logic ordy);
    logic busy;
    beat_t h0;
    beat_t h1;
    @(negedge clk);
    drive(iv, v, ordy);
    cyc++;
    busy = (q0.size() != 0);
    check("in_ready0", 8'(bus0.in_ready), 8'(!busy));
    check("out_valid0", 8'(bus0.out_valid), 8'(busy));
    check("in_ready1", 8'(bus1.in_ready), 8'(!busy));
    check("out_valid1", 8'(bus1.out_valid), 8'(busy));
    if (busy) begin
      h0 = q0[0];
      h1 = q1[0];
      check("code_lsb", 8'(bus0.out_code), 8'(h0.code));
      check("last_lsb", 8'(bus0.out_last), 8'(h0.last));
      check("none_lsb", 8'(bus0.out_none), 8'(h0.none));
      check("code_msb", 8'(bus1.out_code), 8'(h1.code));
      check("last_msb", 8'(bus1.out_last), 8'(h1.last));
      check("none_msb", 8'(bus1.out_none), 8'(h1.none));
      if (ordy) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
        $display("beat cyc=%0d lsb_code=%0d msb_code=%0d last=%0b/%0b none=%0b",
                 cyc, bus0.out_code, bus1.out_code, bus0.out_last, bus1.out_last, bus0.out_none);
      end
    end else if (iv) begin
      push_vec(v);
      $display("capture cyc=%0d vec=%02h", cyc, v);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready0"}, 8'(bus0.in_ready), 8'd1);
    check({tag, "_out_valid0"}, 8'(bus0.out_valid), 8'd0);
    check({tag, "_code0"}, 8'(bus0.out_code), 8'd0);
    check({tag, "_last0"}, 8'(bus0.out_last), 8'd0);
    check({tag, "_none0"}, 8'(bus0.out_none), 8'd0);
    check({tag, "_in_ready1"}, 8'(bus1.in_ready), 8'd1);
    check({tag, "_out_valid1"}, 8'(bus1.out_valid), 8'd0);
  endtask

  // Asynchronous reset pulse away from the clock edge; pending beats are dropped.
  task automatic reset_pulse();
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    q0.delete();
    q1.delete();
    @(negedge clk);
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    $display("reset pulse done cyc=%0d", cyc);
  endtask

  int sweep_start;

  initial begin
    drive(1'b0, 8'h00, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Single set bit: one beat, then idle again.
    tick(1'b1, 8'b0000_0100, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);

    // Three set bits in both orders.
    tick(1'b1, 8'b1001_0010, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 8'h00, 1'b1);

    // All-zero vector: a single "none" beat.
    tick(1'b1, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);

    // Full vector with a 3-cycle stall after the first transfer; inputs churn meanwhile.
    tick(1'b1, 8'hFF, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'h5A, 1'b0);
    tick(1'b0, 8'h33, 1'b0);
    tick(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, 8'h00, 1'b1);

    // Reset in the middle of a vector, then a fresh single-bit vector.
    tick(1'b1, 8'hFF, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    reset_pulse();
    tick(1'b1, 8'h80, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);

    // One-hot sweep at two cycles per vector.
    sweep_start = cyc;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 8'(1 << i), 1'b1);
      tick(1'b0, 8'h00, 1'b1);
    end
    check("sweep_cycles", 8'(cyc - sweep_start), 8'd16);
    tick(1'b0, 8'h00, 1'b1);
    check("scoreboard_empty", 8'(q0.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
